// File: rtl/reducao_acumulada.sv
// reducao_acumulada: frame-wide streaming reduction producing scalar AND/NAND/OR/NOR/XOR/XNOR
// and per-column AND/OR/XOR over up to DEPTH words.
module reducao_acumulada #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clear_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    input  logic             in_last_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [5:0]       s_red_o,
    output logic [WIDTH-1:0] col_and_o,
    output logic [WIDTH-1:0] col_or_o,
    output logic [WIDTH-1:0] col_xor_o,
    output logic [CW-1:0]    count_o
);
    typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] and_q, or_q, xor_q;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             beat, close, r_and, r_or, r_xor;

    // the word count a beat would produce decides whether it closes the frame
    always_comb begin
        beat  = in_valid_i && in_ready_o;
        cnt_d = (state_q == IDLE) ? CW'(1) : cnt_q + CW'(1);
        close = in_last_i || (cnt_d == CW'(DEPTH));
        r_and = &and_q;
        r_or  = |or_q;
        r_xor = ^xor_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            and_q   <= '0;
            or_q    <= '0;
            xor_q   <= '0;
            cnt_q   <= '0;
        end else if (clear_i) begin
            state_q <= IDLE;
            and_q   <= '0;
            or_q    <= '0;
            xor_q   <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE, ACC: if (beat) begin
                    and_q   <= (state_q == IDLE) ? in_data_i : and_q & in_data_i;
                    or_q    <= (state_q == IDLE) ? in_data_i : or_q | in_data_i;
                    xor_q   <= (state_q == IDLE) ? in_data_i : xor_q ^ in_data_i;
                    cnt_q   <= cnt_d;
                    state_q <= close ? DONE : ACC;
                end
                DONE: if (out_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready_o  = (state_q != DONE);
    assign out_valid_o = (state_q == DONE);
    assign s_red_o     = {~r_xor, r_xor, ~r_or, r_or, ~r_and, r_and};
    assign col_and_o   = and_q;
    assign col_or_o    = or_q;
    assign col_xor_o   = xor_q;
    assign count_o     = cnt_q;
endmodule

// File: tb/tb_reducao_acumulada.sv
// tb_reducao_acumulada: random and directed frames against a bit-counting reference model.
module tb_reducao_acumulada;
    localparam int W  = 4;
    localparam int D  = 4;
    localparam int CW = $clog2(D + 1);

    logic          clk = 0, rst_n = 0, clear = 0, in_valid = 0, in_last = 0, out_ready = 0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, out_valid;
    logic [5:0]    s_red;
    logic [W-1:0]  col_and, col_or, col_xor;
    logic [CW-1:0] count;

    int checks = 0, errors = 0;
    logic [W-1:0] fr[$];

    reducao_acumulada #(.WIDTH(W), .DEPTH(D)) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear),
        .in_valid_i(in_valid), .in_ready_o(in_ready), .in_data_i(in_data), .in_last_i(in_last),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .s_red_o(s_red),
        .col_and_o(col_and), .col_or_o(col_or), .col_xor_o(col_xor), .count_o(count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // expected results from counting ones per column and over the whole frame
    task automatic expect_result(input string tag);
        logic [W-1:0] ca, co, cx;
        int n, ones, k;
        logic x;
        n = fr.size();
        ones = 0;
        for (int c = 0; c < W; c++) begin
            k = 0;
            foreach (fr[i]) k += int'(fr[i][c]);
            ca[c] = (k == n);
            co[c] = (k > 0);
            cx[c] = (k % 2 == 1);
            ones += k;
        end
        x = (ones % 2 == 1);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".ready"}, in_ready, 0);
        check({tag, ".s_red"}, s_red, {~x, x, ones == 0, ones > 0, ones != n * W, ones == n * W});
        check({tag, ".col_and"}, col_and, ca);
        check({tag, ".col_or"}, col_or, co);
        check({tag, ".col_xor"}, col_xor, cx);
        check({tag, ".count"}, count, n);
    endtask

    task automatic check_idle(input string tag);
        check({tag, ".valid"}, out_valid, 0);
        check({tag, ".ready"}, in_ready, 1);
        check({tag, ".count"}, count, 0);
        check({tag, ".cols"}, {col_and, col_or, col_xor}, 0);
        check({tag, ".s_red"}, s_red, 6'b101010);
    endtask

    task automatic beat(input logic [W-1:0] d, input logic l, input string tag);
        check({tag, ".beat_ready"}, in_ready, 1);
        in_valid = 1;
        in_data  = d;
        in_last  = l;
        @(posedge clk); #1;
        in_valid = 0;
        in_last  = 0;
        in_data  = W'($urandom);
    endtask

    // fr holds L candidate words; in_last marks word L-1 unless the depth limit closes first
    task automatic send(input int L, input string tag);
        int n;
        n = (L > D) ? D : L;
        for (int i = 0; i < n; i++) begin
            beat(fr[i], i == L - 1, tag);
            if (i < n - 1)
                repeat ($urandom_range(0, 2)) begin
                    in_last = 1'($urandom);
                    @(posedge clk); #1;
                end
            in_last = 0;
        end
        while (fr.size() > n) void'(fr.pop_back());
        expect_result(tag);
    endtask

    task automatic drain(input int hold, input string tag);
        repeat (hold) begin
            in_valid = 1'($urandom);
            in_data  = W'($urandom);
            in_last  = 1'($urandom);
            @(posedge clk); #1;
            expect_result({tag, ".hold"});
        end
        in_valid  = 0;
        in_last   = 0;
        out_ready = 1;
        @(posedge clk); #1;
        out_ready = 0;
        check({tag, ".rel_valid"}, out_valid, 0);
        check({tag, ".rel_ready"}, in_ready, 1);
    endtask

    initial begin
        int L;
        repeat (2) @(posedge clk);
        #1;
        check_idle("reset");
        rst_n = 1;
        @(posedge clk); #1;

        fr = '{4'b0101};             send(1, "single");  drain(0, "single");
        fr = '{4'hF, 4'hF, 4'hF, 4'hF}; send(5, "full");  drain(0, "full");
        fr = '{4'h1, 4'h2, 4'h4, 4'h8}; send(4, "onehot"); drain(0, "onehot");
        fr = '{4'h7};                send(1, "bp");      drain(5, "bp");

        beat(4'hA, 0, "abort"); beat(4'h3, 0, "abort");
        clear = 1;
        @(posedge clk); #1;
        clear = 0;
        check_idle("abort.clr");
        fr = '{4'h1}; send(1, "abort"); drain(0, "abort");

        beat(4'h5, 0, "clrlast");
        in_valid = 1; in_last = 1; in_data = 4'hC; clear = 1;
        @(posedge clk); #1;
        in_valid = 0; in_last = 0; clear = 0;
        check_idle("clrlast");

        fr = '{4'h3}; send(1, "clrdone");
        out_ready = 1; clear = 1;
        @(posedge clk); #1;
        out_ready = 0; clear = 0;
        check_idle("clrdone");

        beat(4'h9, 0, "rstacc"); beat(4'h6, 0, "rstacc");
        #3 rst_n = 0;
        #1 check_idle("rstacc");
        @(posedge clk); #1;
        rst_n = 1;
        fr = '{4'hE, 4'h2}; send(2, "after_rst"); drain(0, "after_rst");

        fr = '{4'hA, 4'hB}; send(2, "rstdone");
        #3 rst_n = 0;
        #1 check_idle("rstdone");
        @(posedge clk); #1;
        rst_n = 1;
        fr = '{4'hC}; send(1, "after_rst2"); drain(0, "after_rst2");

        for (int f = 0; f < 40; f++) begin
            L = $urandom_range(1, D + 2);
            fr = {};
            repeat (L) fr.push_back(W'($urandom));
            send(L, "rand");
            drain($urandom_range(0, 3), "rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
